wb_stage_dual: RTL and testbench
================================

// Module: wb_stage_dual
// PURPOSE
//  Dual-issue EX/WB pipeline register feeding the 8-entry, two-write-port register file.
//  Latches both execute results, drives regWrite/destReg/writeData for write ports 1 and 2,
//  and resolves same-destination conflicts. Forwards WB results to the six read operands
//  so that a read in the same cycle as the write sees the new value. Counts retired instructions.
// PARAMETERS
//  DATA_W   32  result / register data width
//  IDX_W    3   register index width (8 registers)
//  CNT_W    32  retire counter width
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-low reset
//  stall        in   1       hold WB contents; suppress register writes this cycle
//  flush        in   1       drop the incoming EX pair (WB loads invalid)
//  ex_valid1    in   1       slot 1 (older) instruction valid
//  ex_regWrite1 in   1       slot 1 writes a register
//  ex_dest1     in   IDX_W   slot 1 destination index
//  ex_result1   in   DATA_W  slot 1 result
//  ex_valid2 / ex_regWrite2 / ex_dest2 / ex_result2 : same for slot 2 (younger)
//  regWrite1    out  1       to register file write port 1
//  destReg1     out  IDX_W   to register file write port 1
//  writeData1   out  DATA_W  to register file write port 1
//  regWrite2 / destReg2 / writeData2 : same for write port 2
//  src_idx      in   6*IDX_W packed read indices {rm1,rd1_1,rd1_2,rm2,rn2,rd2}, [2:0]=rd2
//  rf_data      in   6*DATA_W packed register-file read data, same order
//  fwd_data     out  6*DATA_W packed forwarded operands, same order
//  retire_count out  CNT_W   instructions retired since reset (wraps)
// BEHAVIOUR
//  - Reset (reset=0, async): wb_valid1/2=0, stored dest/result=0, retire_count=0;
//    hence regWrite1/2=0, destReg1/2=0, writeData1/2=0, fwd_data=rf_data.
//  - Posedge, stall=0, flush=0: WB <= EX fields for both slots (latency 1 cycle).
//  - Posedge, stall=0, flush=1: wb_valid1/2 <= 0; dest/result don't-care.
//  - Posedge, stall=1: all WB state holds; flush ignored (upstream holds EX).
//  - Slots independent: ex_valid2=1 with ex_valid1=0 is legal.
//  - Combinational outputs from WB state:
//    we2 = wb_valid2 & wb_rw2 & ~stall
//    we1 = wb_valid1 & wb_rw1 & ~stall & ~(we2 & dest1==dest2)  (younger wins)
//    regWrite1=we1, regWrite2=we2; destReg/writeData = stored fields always.
//  - Stalled instruction writes exactly once, in the first cycle stall=0.
//  - Forwarding per operand k: if we2 & dest2==src_idx[k] -> result2;
//    else if we1 & dest1==src_idx[k] -> result1; else rf_data[k]. Register 0 is not
//    special: all 8 indices forward. Zero extra latency (purely combinational).
//  - retire_count: at posedge with stall=0 adds wb_valid1+wb_valid2 (0,1,2), including
//    non-writing instructions; modulo 2^CNT_W wrap; held when stall=1.
//  - Reset asserted mid-operation clears WB immediately; pending writes are lost.
// TESTING
//  1. Reset low, then high with no EX valid -> regWrite1/2=0, retire_count=0, fwd_data=rf_data.
//  2. EX slot1 {v=1,rw=1,d=3,r=0xAAAA_0001}, slot2 {v=1,rw=1,d=5,r=0x0000_BEEF} -> next cycle
//     regWrite1=1 destReg1=3 writeData1=0xAAAA_0001, regWrite2=1 destReg2=5; count=2 after next edge.
//  3. Both slots dest=4 with writes -> regWrite1=0, regWrite2=1; src rm1=4 forwards result2.
//  4. Valid pair in WB, stall=1 for 3 cycles -> regWrite1/2=0, count unchanged;
//     stall=0 -> writes asserted one cycle, count +2 once.
//  5. flush=1 with valid EX pair -> next cycle regWrite1/2=0, count unchanged;
//     flush=1 with stall=1 -> WB held.
//  6. retire_count preset near 2^CNT_W-1 (CNT_W=4 build: 15) + 2 retires -> wraps to 1;
//     reset asserted mid-stall -> all outputs zero asynchronously.

Source files
------------

// File: rtl/wb_stage_dual.sv
// Dual-issue EX/WB pipeline register. It holds the two execute results and
// drives both register-file write ports, with the younger slot winning a
// same-destination conflict. It forwards the WB results to six read operands
// and counts retired instructions.
//
// Pipeline control: stall=1 freezes all WB state and the retire counter, and
// suppresses both register writes in that cycle. flush=1 (only when stall=0)
// loads the WB slots as invalid. The stalled pair writes exactly once, in the
// first cycle stall drops.
module wb_stage_dual #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 3,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                ex_valid1,
    input  logic                ex_regWrite1,
    input  logic [IDX_W-1:0]    ex_dest1,
    input  logic [DATA_W-1:0]   ex_result1,
    input  logic                ex_valid2,
    input  logic                ex_regWrite2,
    input  logic [IDX_W-1:0]    ex_dest2,
    input  logic [DATA_W-1:0]   ex_result2,
    output logic                regWrite1,
    output logic [IDX_W-1:0]    destReg1,
    output logic [DATA_W-1:0]   writeData1,
    output logic                regWrite2,
    output logic [IDX_W-1:0]    destReg2,
    output logic [DATA_W-1:0]   writeData2,
    input  logic [6*IDX_W-1:0]  src_idx,
    input  logic [6*DATA_W-1:0] rf_data,
    output logic [6*DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]    retire_count
);

    logic              wb_valid1_q, wb_valid1_d;
    logic              wb_rw1_q, wb_rw1_d;
    logic [IDX_W-1:0]  wb_dest1_q, wb_dest1_d;
    logic [DATA_W-1:0] wb_result1_q, wb_result1_d;
    logic              wb_valid2_q, wb_valid2_d;
    logic              wb_rw2_q, wb_rw2_d;
    logic [IDX_W-1:0]  wb_dest2_q, wb_dest2_d;
    logic [DATA_W-1:0] wb_result2_q, wb_result2_d;
    logic [CNT_W-1:0]  retire_count_q, retire_count_d;

    logic              we1;
    logic              we2;
    logic [CNT_W-1:0]  retire_inc;

    // Both valid bits contribute 0, 1 or 2 retirements per unstalled edge.
    assign retire_inc = CNT_W'(wb_valid1_q) + CNT_W'(wb_valid2_q);

    // Next WB state: hold on stall. Otherwise load EX; a flush only clears the valid bits.
    always_comb begin
        wb_valid1_d    = wb_valid1_q;
        wb_rw1_d       = wb_rw1_q;
        wb_dest1_d     = wb_dest1_q;
        wb_result1_d   = wb_result1_q;
        wb_valid2_d    = wb_valid2_q;
        wb_rw2_d       = wb_rw2_q;
        wb_dest2_d     = wb_dest2_q;
        wb_result2_d   = wb_result2_q;
        retire_count_d = retire_count_q;
        if (!stall) begin
            wb_valid1_d    = ex_valid1 & ~flush;
            wb_rw1_d       = ex_regWrite1;
            wb_dest1_d     = ex_dest1;
            wb_result1_d   = ex_result1;
            wb_valid2_d    = ex_valid2 & ~flush;
            wb_rw2_d       = ex_regWrite2;
            wb_dest2_d     = ex_dest2;
            wb_result2_d   = ex_result2;
            retire_count_d = retire_count_q + retire_inc;
        end
    end

    // WB register and retire counter, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid1_q    <= 1'b0;
            wb_rw1_q       <= 1'b0;
            wb_dest1_q     <= '0;
            wb_result1_q   <= '0;
            wb_valid2_q    <= 1'b0;
            wb_rw2_q       <= 1'b0;
            wb_dest2_q     <= '0;
            wb_result2_q   <= '0;
            retire_count_q <= '0;
        end else begin
            wb_valid1_q    <= wb_valid1_d;
            wb_rw1_q       <= wb_rw1_d;
            wb_dest1_q     <= wb_dest1_d;
            wb_result1_q   <= wb_result1_d;
            wb_valid2_q    <= wb_valid2_d;
            wb_rw2_q       <= wb_rw2_d;
            wb_dest2_q     <= wb_dest2_d;
            wb_result2_q   <= wb_result2_d;
            retire_count_q <= retire_count_d;
        end
    end

    // Write enables: the younger slot 2 suppresses slot 1 when both target one register.
    always_comb begin
        we2 = wb_valid2_q & wb_rw2_q & ~stall;
        we1 = wb_valid1_q & wb_rw1_q & ~stall & ~(we2 && (wb_dest1_q == wb_dest2_q));
    end

    // Same-cycle bypass for each of the six read operands, with the younger write first.
    always_comb begin
        fwd_data = rf_data;
        for (int k = 0; k < 6; k++) begin
            if (we2 && (wb_dest2_q == src_idx[k*IDX_W +: IDX_W])) begin
                fwd_data[k*DATA_W +: DATA_W] = wb_result2_q;
            end else if (we1 && (wb_dest1_q == src_idx[k*IDX_W +: IDX_W])) begin
                fwd_data[k*DATA_W +: DATA_W] = wb_result1_q;
            end
        end
    end

    assign regWrite1    = we1;
    assign destReg1     = wb_dest1_q;
    assign writeData1   = wb_result1_q;
    assign regWrite2    = we2;
    assign destReg2     = wb_dest2_q;
    assign writeData2   = wb_result2_q;
    assign retire_count = retire_count_q;

endmodule

// File: tb/tb_wb_stage_dual.sv
// Bench for wb_stage_dual. A 32-bit-counter instance and a 4-bit-counter
// instance share all inputs. A behavioural model of the WB contents is checked
// against the DUT on every falling edge. Directed steps add literal checks.
module tb_wb_stage_dual;

    logic         clk;
    logic         reset;
    logic         stall;
    logic         flush;
    logic         ex_valid1, ex_regWrite1, ex_valid2, ex_regWrite2;
    logic [2:0]   ex_dest1, ex_dest2;
    logic [31:0]  ex_result1, ex_result2;
    logic         regWrite1, regWrite2;
    logic [2:0]   destReg1, destReg2;
    logic [31:0]  writeData1, writeData2;
    logic [17:0]  src_idx;
    logic [191:0] rf_data;
    logic [191:0] fwd_data;
    logic [31:0]  retire_count;

    logic         s_regWrite1, s_regWrite2;
    logic [2:0]   s_destReg1, s_destReg2;
    logic [31:0]  s_writeData1, s_writeData2;
    logic [191:0] s_fwd_data;
    logic [3:0]   s_retire_count;

    int n_vec = 0;
    int n_err = 0;

    wb_stage_dual #(.DATA_W(32), .IDX_W(3), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_valid1(ex_valid1), .ex_regWrite1(ex_regWrite1), .ex_dest1(ex_dest1), .ex_result1(ex_result1),
        .ex_valid2(ex_valid2), .ex_regWrite2(ex_regWrite2), .ex_dest2(ex_dest2), .ex_result2(ex_result2),
        .regWrite1(regWrite1), .destReg1(destReg1), .writeData1(writeData1),
        .regWrite2(regWrite2), .destReg2(destReg2), .writeData2(writeData2),
        .src_idx(src_idx), .rf_data(rf_data), .fwd_data(fwd_data), .retire_count(retire_count)
    );

    wb_stage_dual #(.DATA_W(32), .IDX_W(3), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_valid1(ex_valid1), .ex_regWrite1(ex_regWrite1), .ex_dest1(ex_dest1), .ex_result1(ex_result1),
        .ex_valid2(ex_valid2), .ex_regWrite2(ex_regWrite2), .ex_dest2(ex_dest2), .ex_result2(ex_result2),
        .regWrite1(s_regWrite1), .destReg1(s_destReg1), .writeData1(s_writeData1),
        .regWrite2(s_regWrite2), .destReg2(s_destReg2), .writeData2(s_writeData2),
        .src_idx(src_idx), .rf_data(rf_data), .fwd_data(s_fwd_data), .retire_count(s_retire_count)
    );

    // Clock: 10-time-unit period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the WB contents: the instruction pair that sits in
    // writeback, whether its stored fields are defined, and the total retired.
    logic        m_v1, m_rw1, m_v2, m_rw2;
    logic        m_known1, m_known2;
    logic [2:0]  m_d1, m_d2;
    logic [31:0] m_r1, m_r2;
    logic [31:0] m_cnt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_v1 = 0; m_rw1 = 0; m_d1 = 0; m_r1 = 0; m_known1 = 1;
            m_v2 = 0; m_rw2 = 0; m_d2 = 0; m_r2 = 0; m_known2 = 1;
            m_cnt = 0;
        end else if (!stall) begin
            m_cnt = m_cnt + 32'(m_v1) + 32'(m_v2);
            m_v1 = ex_valid1 && !flush; m_rw1 = ex_regWrite1; m_d1 = ex_dest1; m_r1 = ex_result1;
            m_v2 = ex_valid2 && !flush; m_rw2 = ex_regWrite2; m_d2 = ex_dest2; m_r2 = ex_result2;
            m_known1 = !flush;
            m_known2 = !flush;
        end
    end

    // Compare process: list which slot ends up owning each register this cycle,
    // writing in program order so the later write wins. Then derive all outputs.
    int          owner[8];
    logic        e_we1, e_we2;
    logic [31:0] e_op;
    always @(negedge clk) begin
        for (int i = 0; i < 8; i++) owner[i] = 0;
        if (!stall && m_v1 && m_rw1) owner[m_d1] = 1;
        if (!stall && m_v2 && m_rw2) owner[m_d2] = 2;
        e_we2 = !stall && m_v2 && m_rw2;
        e_we1 = !stall && m_v1 && m_rw1 && (owner[m_d1] == 1);
        check("cmp_regWrite1", 64'(regWrite1), 64'(e_we1));
        check("cmp_regWrite2", 64'(regWrite2), 64'(e_we2));
        if (m_known1) begin
            check("cmp_destReg1", 64'(destReg1), 64'(m_d1));
            check("cmp_writeData1", 64'(writeData1), 64'(m_r1));
        end
        if (m_known2) begin
            check("cmp_destReg2", 64'(destReg2), 64'(m_d2));
            check("cmp_writeData2", 64'(writeData2), 64'(m_r2));
        end
        for (int k = 0; k < 6; k++) begin
            case (owner[src_idx[k*3 +: 3]])
                2:       e_op = m_r2;
                1:       e_op = m_r1;
                default: e_op = rf_data[k*32 +: 32];
            endcase
            check($sformatf("cmp_fwd%0d", k), 64'(fwd_data[k*32 +: 32]), 64'(e_op));
        end
        check("cmp_retire_count", 64'(retire_count), 64'(m_cnt));
        check("cmp_small_retire_count", 64'(s_retire_count), 64'(m_cnt[3:0]));
        check("cmp_small_regWrite1", 64'(s_regWrite1), 64'(e_we1));
        check("cmp_small_regWrite2", 64'(s_regWrite2), 64'(e_we2));
    end

    // Driver tasks: inputs change 2 units after a rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ex(input logic v1, input logic rw1, input logic [2:0] d1, input logic [31:0] r1,
                          input logic v2, input logic rw2, input logic [2:0] d2, input logic [31:0] r2);
        ex_valid1 = v1; ex_regWrite1 = rw1; ex_dest1 = d1; ex_result1 = r1;
        ex_valid2 = v2; ex_regWrite2 = rw2; ex_dest2 = d2; ex_result2 = r2;
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        src_idx = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        for (int k = 0; k < 6; k++) rf_data[k*32 +: 32] = 32'hF000_0000 | 32'(k);

        // 1: reset state, then an idle run with nothing valid
        #3;
        check("rst_regWrite1", 64'(regWrite1), 64'd0);
        check("rst_count", 64'(retire_count), 64'd0);
        check("rst_fwd_rm1", 64'(fwd_data[191:160]), 64'hF000_0005);
        #19 reset = 1'b1;
        tick(); tick();
        check("idle_regWrite2", 64'(regWrite2), 64'd0);
        check("idle_count", 64'(retire_count), 64'd0);

        // 2: a plain pair writes both ports one cycle later
        set_ex(1, 1, 3'd3, 32'hAAAA_0001, 1, 1, 3'd5, 32'h0000_BEEF);
        tick();
        check("t2_regWrite1", 64'(regWrite1), 64'd1);
        check("t2_destReg1", 64'(destReg1), 64'd3);
        check("t2_writeData1", 64'(writeData1), 64'hAAAA_0001);
        check("t2_regWrite2", 64'(regWrite2), 64'd1);
        check("t2_destReg2", 64'(destReg2), 64'd5);

        // 3: both slots target r4, so the younger slot wins the write and the bypass
        set_ex(1, 1, 3'd4, 32'h1111_1111, 1, 1, 3'd4, 32'h2222_2222);
        tick();
        check("t3_count", 64'(retire_count), 64'd2);
        check("t3_regWrite1", 64'(regWrite1), 64'd0);
        check("t3_regWrite2", 64'(regWrite2), 64'd1);
        src_idx[17:15] = 3'd4;
        #1;
        check("t3_fwd_rm1", 64'(fwd_data[191:160]), 64'h2222_2222);
        check("t3_fwd_rd2", 64'(fwd_data[31:0]), 64'hF000_0000);

        // 4: a pair held by a three-cycle stall writes once, when the stall drops
        set_ex(1, 1, 3'd1, 32'h10, 1, 1, 3'd2, 32'h20);
        tick();
        check("t4_count_load", 64'(retire_count), 64'd4);
        stall = 1'b1;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("t4_stall_we1", 64'(regWrite1), 64'd0);
        check("t4_stall_we2", 64'(regWrite2), 64'd0);
        tick(); tick(); tick();
        check("t4_stall_count", 64'(retire_count), 64'd4);
        stall = 1'b0;
        #1;
        check("t4_release_we1", 64'(regWrite1), 64'd1);
        check("t4_release_we2", 64'(regWrite2), 64'd1);
        check("t4_release_data1", 64'(writeData1), 64'h10);
        tick();
        check("t4_count_after", 64'(retire_count), 64'd6);
        check("t4_single_write", 64'(regWrite1), 64'd0);

        // 5: flush drops the incoming pair; flush during a stall is ignored
        set_ex(1, 1, 3'd6, 32'h60, 1, 1, 3'd7, 32'h70);
        flush = 1'b1;
        tick();
        check("t5_flush_we1", 64'(regWrite1), 64'd0);
        check("t5_flush_we2", 64'(regWrite2), 64'd0);
        flush = 1'b0;
        tick();
        check("t5_flush_count", 64'(retire_count), 64'd6);
        stall = 1'b1;
        flush = 1'b1;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("t5_held_count", 64'(retire_count), 64'd6);
        stall = 1'b0;
        flush = 1'b0;
        #1;
        check("t5_held_we1", 64'(regWrite1), 64'd1);
        check("t5_held_dest1", 64'(destReg1), 64'd6);
        check("t5_held_we2", 64'(regWrite2), 64'd1);
        check("t5_held_data2", 64'(writeData2), 64'h70);

        // 6a: an asynchronous reset in mid-stall clears everything at once
        stall = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("t6_rst_we1", 64'(regWrite1), 64'd0);
        check("t6_rst_we2", 64'(regWrite2), 64'd0);
        check("t6_rst_dest1", 64'(destReg1), 64'd0);
        check("t6_rst_data2", 64'(writeData2), 64'd0);
        check("t6_rst_count", 64'(retire_count), 64'd0);
        check("t6_rst_fwd_rm1", 64'(fwd_data[191:160]), 64'hF000_0005);
        #1 reset = 1'b1;
        stall = 1'b0;

        // 6b: drive the 4-bit counter to 15, then two more retirements wrap it to 1
        set_ex(1, 0, 3'd0, 32'h0, 1, 1, 3'd1, 32'h1);
        for (int i = 0; i < 7; i++) tick();
        check("t6_count12", 64'(retire_count), 64'd12);
        set_ex(1, 1, 3'd2, 32'h2, 0, 0, 3'd0, 32'h0);
        tick();
        check("t6_count14", 64'(s_retire_count), 64'd14);
        set_ex(1, 1, 3'd3, 32'h3, 1, 1, 3'd4, 32'h4);
        tick();
        check("t6_small15", 64'(s_retire_count), 64'd15);
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("t6_small_wrap", 64'(s_retire_count), 64'd1);
        check("t6_big17", 64'(retire_count), 64'd17);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
